// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Holds the default datapath width, the control-bundle layout (both as bit
// indices and as a packed struct), and the edge-action encoding used by the
// ID/EX register.
package cpu_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned CTRL_W    = 8;
  localparam int unsigned REG_IDX_W = 5;

  // Bit positions inside the control bundle, MSB first
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_READ   = 6;
  localparam int unsigned CTRL_MEM_WRITE  = 5;
  localparam int unsigned CTRL_MEM_TO_REG = 4;
  localparam int unsigned CTRL_ALU_SRC    = 3;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_ALU_OP_HI  = 1;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // What the ID/EX register does on the next rising edge
  typedef enum logic {
    EDGE_CAPTURE = 1'b0,
    EDGE_BUBBLE  = 1'b1
  } edge_act_e;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a load whose destination is a source
// that the valid instruction in ID actually reads. Writes to x0 never hazard.
//   ex_valid, ex_mem_read, ex_rd : state of the EX stage
//   id_valid, id_rs1/2, id_uses_rs1/2 : ID instruction and its source usage
//   load_use : hazard present this cycle
module hazard_unit (
  input  logic                           ex_valid,
  input  logic                           ex_mem_read,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  ex_rd,
  input  logic                           id_valid,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  id_rs1,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  id_rs2,
  input  logic                           id_uses_rs1,
  input  logic                           id_uses_rs2,
  output logic                           load_use
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1  = (ex_rd == id_rs1) & id_uses_rs1;
    hit_rs2  = (ex_rd == id_rs2) & id_uses_rs2;
    load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid
             & (hit_rs1 | hit_rs2);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall generation, writeback bypass
// and a saturating stall counter.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   id_*            : decoded instruction fields and register-file read data
//   wb_we/rd/data   : writeback port (same values the register file sees)
//   flush           : kill the ID instruction (branch taken)
//   stall           : combinational, freezes PC and IF/ID
//   ex_*            : registered EX-stage copies of the ID fields
//   stall_count     : load-use stall cycles since reset, saturating
module id_ex_pipe #(
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [XLEN-1:0]                id_pc,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  id_rs1,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  id_rs2,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  id_rd,
  input  logic                           id_uses_rs1,
  input  logic                           id_uses_rs2,
  input  logic [XLEN-1:0]                id_rd1,
  input  logic [XLEN-1:0]                id_rd2,
  input  logic [XLEN-1:0]                id_imm,
  input  logic [cpu_pkg::CTRL_W-1:0]     id_ctrl,
  input  logic                           wb_we,
  input  logic [cpu_pkg::REG_IDX_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           flush,
  output logic                           stall,
  output logic                           ex_valid,
  output logic [XLEN-1:0]                ex_pc,
  output logic [cpu_pkg::REG_IDX_W-1:0]  ex_rs1,
  output logic [cpu_pkg::REG_IDX_W-1:0]  ex_rs2,
  output logic [cpu_pkg::REG_IDX_W-1:0]  ex_rd,
  output logic [XLEN-1:0]                ex_rd1,
  output logic [XLEN-1:0]                ex_rd2,
  output logic [XLEN-1:0]                ex_imm,
  output logic [cpu_pkg::CTRL_W-1:0]     ex_ctrl,
  output logic [CNT_W-1:0]               stall_count
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t                ex_ctrl_s;
  logic                 load_use;
  edge_act_e            edge_act;
  logic [XLEN-1:0]      fwd_rd1;
  logic [XLEN-1:0]      fwd_rd2;
  logic [CTRL_W-1:0]    cap_ctrl;

  assign ex_ctrl_s = ctrl_t'(ex_ctrl);

  hazard_unit u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl_s.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  // Flush outranks stall: a killed instruction must not hold the front end.
  always_comb begin
    stall    = load_use & ~flush;
    edge_act = (flush | stall) ? EDGE_BUBBLE : EDGE_CAPTURE;
  end

  // Writeback bypass. The wb_rd != 0 qualifier is implied: a match only
  // reaches the bypass arm when id_rsN is already known to be non-zero.
  always_comb begin
    if (id_rs1 == '0)
      fwd_rd1 = '0;
    else if (wb_we && (wb_rd == id_rs1))
      fwd_rd1 = wb_data;
    else
      fwd_rd1 = id_rd1;

    if (id_rs2 == '0)
      fwd_rd2 = '0;
    else if (wb_we && (wb_rd == id_rs2))
      fwd_rd2 = wb_data;
    else
      fwd_rd2 = id_rd2;

    cap_ctrl = id_valid ? id_ctrl : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (edge_act == EDGE_BUBBLE) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_rd1   <= fwd_rd1;
      ex_rd2   <= fwd_rd2;
      ex_imm   <= id_imm;
      ex_ctrl  <= cap_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int unsigned SAT = 15;

  localparam logic [7:0] C_LOAD = 8'hD8; // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [7:0] C_ADD  = 8'h82; // reg_write, alu_op=2

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            id_valid = 1'b0;
  logic [63:0]     id_pc = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [63:0]     id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [7:0]      id_ctrl = '0;
  logic            wb_we = 1'b0;
  logic [4:0]      wb_rd = '0;
  logic [63:0]     wb_data = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic            ex_valid;
  logic [63:0]     ex_pc;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [63:0]     ex_rd1, ex_rd2, ex_imm;
  logic [7:0]      ex_ctrl;
  logic [CNT_W-1:0] stall_count;

  id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [7:0]  ctrl;
  } ex_t;

  // Reference model state: contents of the EX stage and the stall tally
  ex_t         m_ex;
  int unsigned m_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic ex_t observed();
    ex_t o;
    o = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl};
    return o;
  endfunction

  // Value the instruction should see for a source register
  function automatic logic [63:0] operand(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return 64'd0;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic model_load_use();
    if (!(m_ex.valid && m_ex.ctrl[6] && m_ex.rd != 5'd0 && id_valid)) return 1'b0;
    return (m_ex.rd == id_rs1 && id_uses_rs1) || (m_ex.rd == id_rs2 && id_uses_rs2);
  endfunction

  function automatic logic model_stall();
    return model_load_use() && !flush;
  endfunction

  task automatic tick();
    ex_t nx;
    logic st;
    st = model_stall();
    if (flush || st) nx = '0;
    else begin
      nx.valid = id_valid;
      nx.pc    = id_pc;
      nx.rs1   = id_rs1;
      nx.rs2   = id_rs2;
      nx.rd    = id_rd;
      nx.rd1   = operand(id_rs1, id_rd1);
      nx.rd2   = operand(id_rs2, id_rd2);
      nx.imm   = id_imm;
      nx.ctrl  = id_valid ? id_ctrl : 8'h00;
    end
    @(posedge clk);
    m_ex = nx;
    if (st && m_cnt < SAT) m_cnt++;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd1 = d1; id_rd2 = d2;
    id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [63:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic test_reset();
    set_id(1'b1, 64'h1000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 64'd11, 64'd22, 64'd33, C_ADD);
    set_wb(1'b0, 5'd0, 64'd0);
    flush = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid got %b exp 1", ex_valid); end
    reset = 1'b1;
    #1;
    m_ex = '0; m_cnt = 0;
    checks++;
    if (observed() !== ex_t'(0)) begin errors++; $display("FAIL reset_ex got %h exp 0", observed()); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++;
    if (stall_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_count); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_normal();
    set_id(1'b1, 64'h2000, 5'd1, 5'd3, 5'd7, 1'b1, 1'b1, 64'd56, 64'd47, 64'hFFFF_FFFF_FFFF_FFF0, C_ADD);
    set_wb(1'b0, 5'd0, 64'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL normal_stall got %b exp 0", stall); end
    tick();
    checks++;
    if (ex_rd1 !== 64'd56 || ex_rd2 !== 64'd47 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL normal_fields got rd1=%0d rd2=%0d v=%b exp 56 47 1", ex_rd1, ex_rd2, ex_valid);
    end
    checks++;
    if (observed() !== m_ex) begin errors++; $display("FAIL normal_ex got %h exp %h", observed(), m_ex); end
    // id_valid low: fields flow through but the slot is marked empty
    set_id(1'b0, 64'h2004, 5'd2, 5'd4, 5'd8, 1'b1, 1'b1, 64'd5, 64'd6, 64'd7, C_ADD);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc !== 64'h2004) begin
      errors++; $display("FAIL invalid_capture got v=%b ctrl=%h pc=%h exp 0 00 2004", ex_valid, ex_ctrl, ex_pc);
    end
    checks++;
    if (observed() !== m_ex) begin errors++; $display("FAIL invalid_ex got %h exp %h", observed(), m_ex); end
  endtask

  task automatic test_load_use();
    int unsigned c0;
    set_id(1'b1, 64'h3000, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 64'd1, 64'd2, 64'd3, C_LOAD);
    tick();
    set_id(1'b1, 64'h3004, 5'd5, 5'd9, 5'd10, 1'b1, 1'b1, 64'd100, 64'd200, 64'd0, C_ADD);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    c0 = m_cnt;
    tick();
    checks++;
    if (observed() !== m_ex || ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp %h", observed(), m_ex); end
    checks++;
    if (stall_count !== CNT_W'(c0 + 1) || stall_count !== 4'd1) begin
      errors++; $display("FAIL lu_cnt got %0d exp %0d", stall_count, c0 + 1);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_pc !== 64'h3004) begin
      errors++; $display("FAIL lu_capture got v=%b rs1=%0d pc=%h exp 1 5 3004", ex_valid, ex_rs1, ex_pc);
    end
    checks++;
    if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", stall_count); end
  endtask

  task automatic test_bypass();
    // wb_we, wb_rd, wb_data, rs1, rd1, rs2, rd2, exp_rd1, exp_rd2
    logic [63:0] t [0:4][0:8] = '{
      '{64'd1, 64'd3, 64'd99, 64'd1, 64'd56,  64'd3, 64'd47, 64'd56, 64'd99},
      '{64'd1, 64'd0, 64'd99, 64'd0, 64'd123, 64'd3, 64'd47, 64'd0,  64'd47},
      '{64'd1, 64'd4, 64'd77, 64'd4, 64'd10,  64'd4, 64'd20, 64'd77, 64'd77},
      '{64'd0, 64'd3, 64'd99, 64'd3, 64'd10,  64'd2, 64'd47, 64'd10, 64'd47},
      '{64'd1, 64'd0, 64'd55, 64'd0, 64'd8,   64'd0, 64'd9,  64'd0,  64'd0}
    };
    for (int i = 0; i < 5; i++) begin
      set_wb(t[i][0][0], t[i][1][4:0], t[i][2]);
      set_id(1'b1, 64'h4000 + 64'(i * 4), t[i][3][4:0], t[i][5][4:0], 5'd8, 1'b1, 1'b1,
             t[i][4], t[i][6], 64'd0, C_ADD);
      tick();
      checks++;
      if (ex_rd1 !== t[i][7] || ex_rd2 !== t[i][8]) begin
        errors++; $display("FAIL bypass_%0d got rd1=%0d rd2=%0d exp %0d %0d", i, ex_rd1, ex_rd2, t[i][7], t[i][8]);
      end
      checks++;
      if (observed() !== m_ex) begin errors++; $display("FAIL bypass_ex_%0d got %h exp %h", i, observed(), m_ex); end
    end
    set_wb(1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_flush_vs_stall();
    int unsigned c0;
    set_id(1'b1, 64'h5000, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 64'd1, 64'd2, 64'd3, C_LOAD);
    tick();
    set_id(1'b1, 64'h5004, 5'd9, 5'd5, 5'd10, 1'b0, 1'b1, 64'd1, 64'd2, 64'd0, C_ADD);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    c0 = m_cnt;
    tick();
    checks++;
    if (observed() !== m_ex || ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got %h exp %h", observed(), m_ex); end
    checks++;
    if (stall_count !== CNT_W'(c0)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", stall_count, c0); end
    flush = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || observed() !== m_ex) begin errors++; $display("FAIL flush_after got %h exp %h", observed(), m_ex); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 64'h6000, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 64'd1, 64'd2, 64'd3, C_LOAD);
    tick();
    set_id(1'b1, 64'h6004, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 64'd42, 64'd0, 64'd9, C_ADD);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall got %b exp 1", stall); end
    reset = 1'b1;
    #1;
    m_ex = '0; m_cnt = 0;
    checks++;
    if (observed() !== ex_t'(0) || stall !== 1'b0 || stall_count !== '0) begin
      errors++; $display("FAIL rms_clear got ex=%h stall=%b cnt=%0d exp 0 0 0", observed(), stall, stall_count);
    end
    reset = 1'b0;
    #1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 64'h6004 || ex_rd1 !== 64'd42) begin
      errors++; $display("FAIL rms_capture got v=%b pc=%h rd1=%0d exp 1 6004 42", ex_valid, ex_pc, ex_rd1);
    end
    checks++;
    if (observed() !== m_ex) begin errors++; $display("FAIL rms_ex got %h exp %h", observed(), m_ex); end
  endtask

  task automatic test_saturation();
    int stalls;
    logic exp_st;
    stalls = 0;
    // A load that reads its own destination re-triggers every other cycle
    set_id(1'b1, 64'h7000, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 64'd1, 64'd0, 64'd0, C_LOAD);
    set_wb(1'b0, 5'd0, 64'd0);
    flush = 1'b0;
    #1;
    for (int k = 0; k < 60 && stalls < 20; k++) begin
      exp_st = model_stall();
      checks++;
      if (stall !== exp_st) begin errors++; $display("FAIL sat_stall_%0d got %b exp %b", k, stall, exp_st); end
      if (exp_st) stalls++;
      tick();
      checks++;
      if (stall_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", k, stall_count, m_cnt); end
    end
    checks++;
    if (stalls < 20) begin errors++; $display("FAIL sat_timeout got %0d stalls exp 20", stalls); end
    checks++;
    if (stall_count !== 4'hF) begin errors++; $display("FAIL sat_final got %0d exp 15", stall_count); end
  endtask

  task automatic test_random();
    logic exp_st;
    for (int k = 0; k < 300; k++) begin
      set_id($urandom_range(0, 3) != 0, {$urandom, $urandom},
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? C_LOAD : 8'($urandom));
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      flush = ($urandom_range(0, 7) == 0);
      #1;
      exp_st = model_stall();
      checks++;
      if (stall !== exp_st) begin errors++; $display("FAIL rnd_stall_%0d got %b exp %b", k, stall, exp_st); end
      tick();
      checks++;
      if (observed() !== m_ex) begin errors++; $display("FAIL rnd_ex_%0d got %h exp %h", k, observed(), m_ex); end
      checks++;
      if (stall_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt_%0d got %0d exp %0d", k, stall_count, m_cnt); end
    end
    flush = 1'b0;
  endtask

  initial begin
    m_ex = '0;
    m_cnt = 0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_normal();
    test_load_use();
    test_bypass();
    test_flush_vs_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
